// File: rtl/breakout_pkg.sv
// Shared encodings for the Breakout sequencer: draw opcodes, FSM states
// and small helpers used to size and decode the controller.
package breakout_pkg;

  localparam logic [2:0] OP_NOP          = 3'd0;
  localparam logic [2:0] OP_SCREEN_CLEAR = 3'd1;
  localparam logic [2:0] OP_BRICK_FILL   = 3'd2;
  localparam logic [2:0] OP_BRICK_CLEAR  = 3'd3;
  localparam logic [2:0] OP_PADDLE_ERASE = 3'd4;
  localparam logic [2:0] OP_PADDLE_DRAW  = 3'd5;
  localparam logic [2:0] OP_BALL_ERASE   = 3'd6;
  localparam logic [2:0] OP_BALL_DRAW    = 3'd7;

  typedef enum logic [4:0] {
    ST_INIT        = 5'd0,
    ST_CLR         = 5'd1,
    ST_POP         = 5'd2,
    ST_RESET_LOOP  = 5'd3,
    ST_WAIT_FRAME  = 5'd4,
    ST_MOVE_PAD    = 5'd5,
    ST_ERASE_PAD   = 5'd6,
    ST_DRAW_PAD    = 5'd7,
    ST_ERASE_BALL  = 5'd8,
    ST_MOVE_BALL   = 5'd9,
    ST_DRAW_BALL   = 5'd10,
    ST_COLLIDE     = 5'd11,
    ST_REMOVE      = 5'd12,
    ST_LOST        = 5'd13,
    ST_GAME_OVER   = 5'd14,
    ST_LEVEL_CLEAR = 5'd15
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [2:0] state_op(input state_e st);
    case (st)
      ST_CLR:        return OP_SCREEN_CLEAR;
      ST_POP:        return OP_BRICK_FILL;
      ST_REMOVE:     return OP_BRICK_CLEAR;
      ST_ERASE_PAD:  return OP_PADDLE_ERASE;
      ST_DRAW_PAD:   return OP_PADDLE_DRAW;
      ST_ERASE_BALL: return OP_BALL_ERASE;
      ST_DRAW_BALL:  return OP_BALL_DRAW;
      default:       return OP_NOP;
    endcase
  endfunction

  function automatic logic is_draw_state(input state_e st);
    return (state_op(st) != OP_NOP);
  endfunction

endpackage

// File: rtl/breakout_draw_req.sv
// Draw-engine handshake: emits the one-cycle start pulse for a new job and
// qualifies draw_done so a completion is only taken after the job's first cycle.
module breakout_draw_req (
  input  logic clk,
  input  logic resetn,
  input  logic launch,
  input  logic in_draw,
  input  logic draw_done,
  output logic draw_start,
  output logic done_accept
);

  logic first_q, first_d;
  logic issued_q, issued_d;

  assign done_accept = in_draw && issued_q && !first_q && draw_done;
  assign draw_start  = first_q;

  // First-cycle marker and issued flag for the job in progress.
  always_comb begin
    first_d = launch;
    if (launch) begin
      issued_d = 1'b0;
    end else if (first_q) begin
      issued_d = 1'b1;
    end else if (done_accept) begin
      issued_d = 1'b0;
    end else begin
      issued_d = issued_q;
    end
  end

  // Handshake state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      first_q  <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      first_q  <= first_d;
      issued_q <= issued_d;
    end
  end

endmodule

// File: rtl/breakout_sequencer.sv
// Breakout game controller: paces frames, sequences draw jobs through one
// draw engine and keeps the brick bitmap, lives and end-of-game status.
module breakout_sequencer
  import breakout_pkg::*;
#(
  parameter int NUM_BRICKS = 12,
  parameter int BIDX_W     = clog2(NUM_BRICKS + 1),
  parameter int LIVES      = 3,
  parameter int LIFE_W     = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  frame_tick,
  input  logic                  draw_done,
  input  logic [BIDX_W-1:0]     hit_brick,
  input  logic                  ball_lost,
  output logic                  draw_start,
  output logic [2:0]            draw_op,
  output logic [BIDX_W-1:0]     draw_idx,
  output logic                  ld_reset_initial,
  output logic                  ld_reset_loop,
  output logic                  ld_move_paddle,
  output logic                  ld_move_ball,
  output logic                  ld_collide,
  output logic [NUM_BRICKS-1:0] brick_alive,
  output logic [LIFE_W-1:0]     lives,
  output logic                  game_over,
  output logic                  level_clear
);

  state_e                  state_q, state_d;
  logic [BIDX_W-1:0]       idx_q, idx_d;
  logic [NUM_BRICKS-1:0]   alive_q, alive_d;
  logic [LIFE_W-1:0]       lives_q, lives_d;
  logic                    pend_q, pend_d;
  logic [2:0]              draw_op_q, draw_op_d;
  logic [BIDX_W-1:0]       draw_idx_q, draw_idx_d;
  logic [4:0]              ld_q, ld_d;
  logic [1:0]              status_q, status_d;

  logic [NUM_BRICKS-1:0]   hit_mask_s, idx_mask_s, alive_left_s;
  logic                    hit_ok_s, done_accept_s, launch_s;

  assign hit_mask_s   = NUM_BRICKS'(1'b1) << (hit_brick - BIDX_W'(1));
  assign idx_mask_s   = NUM_BRICKS'(1'b1) << (idx_q - BIDX_W'(1));
  assign alive_left_s = alive_q & ~idx_mask_s;
  assign hit_ok_s     = (hit_brick != '0) && (hit_brick <= BIDX_W'(NUM_BRICKS))
                        && ((alive_q & hit_mask_s) != '0);
  // A POP that completes and stays in POP needs a fresh start pulse.
  assign launch_s     = is_draw_state(state_d) && ((state_d != state_q) || done_accept_s);

  breakout_draw_req u_draw_req (
    .clk         (clk),
    .resetn      (resetn),
    .launch      (launch_s),
    .in_draw     (is_draw_state(state_q)),
    .draw_done   (draw_done),
    .draw_start  (draw_start),
    .done_accept (done_accept_s)
  );

  // Next state, brick/lives bookkeeping and the single-deep frame-pending flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    alive_d = alive_q;
    lives_d = lives_q;
    if (state_q == ST_WAIT_FRAME) begin
      pend_d = 1'b0;
    end else if (frame_tick && (state_q != ST_GAME_OVER) && (state_q != ST_LEVEL_CLEAR)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
    case (state_q)
      ST_INIT: begin
        alive_d = '1;
        lives_d = LIFE_W'(LIVES);
        idx_d   = '0;
        state_d = ST_CLR;
      end
      ST_CLR: begin
        if (done_accept_s) begin
          idx_d   = BIDX_W'(1);
          state_d = ST_POP;
        end else begin
          state_d = ST_CLR;
        end
      end
      ST_POP: begin
        if (!done_accept_s) begin
          state_d = ST_POP;
        end else if (idx_q == BIDX_W'(NUM_BRICKS)) begin
          state_d = ST_RESET_LOOP;
        end else begin
          idx_d   = idx_q + BIDX_W'(1);
          state_d = ST_POP;
        end
      end
      ST_RESET_LOOP: state_d = ST_WAIT_FRAME;
      ST_WAIT_FRAME: state_d = (frame_tick || pend_q) ? ST_MOVE_PAD : ST_WAIT_FRAME;
      ST_MOVE_PAD:   state_d = ST_ERASE_PAD;
      ST_ERASE_PAD:  state_d = done_accept_s ? ST_DRAW_PAD : ST_ERASE_PAD;
      ST_DRAW_PAD:   state_d = done_accept_s ? ST_ERASE_BALL : ST_DRAW_PAD;
      ST_ERASE_BALL: state_d = done_accept_s ? ST_MOVE_BALL : ST_ERASE_BALL;
      ST_MOVE_BALL:  state_d = ST_DRAW_BALL;
      ST_DRAW_BALL:  state_d = done_accept_s ? ST_COLLIDE : ST_DRAW_BALL;
      ST_COLLIDE: begin
        if (ball_lost) begin
          state_d = ST_LOST;
        end else if (hit_ok_s) begin
          idx_d   = hit_brick;
          state_d = ST_REMOVE;
        end else begin
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_REMOVE: begin
        if (done_accept_s) begin
          alive_d = alive_left_s;
          state_d = (alive_left_s == '0) ? ST_LEVEL_CLEAR : ST_RESET_LOOP;
        end else begin
          state_d = ST_REMOVE;
        end
      end
      ST_LOST: begin
        lives_d = (lives_q != '0) ? (lives_q - LIFE_W'(1)) : lives_q;
        state_d = (lives_q <= LIFE_W'(1)) ? ST_GAME_OVER : ST_RESET_LOOP;
      end
      ST_GAME_OVER: state_d = start ? ST_INIT : ST_GAME_OVER;
      ST_LEVEL_CLEAR: begin
        if (start) begin
          alive_d = '1;
          idx_d   = BIDX_W'(1);
          state_d = ST_POP;
        end else begin
          state_d = ST_LEVEL_CLEAR;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs are decoded from the upcoming state so each one comes from a flop.
  always_comb begin
    draw_op_d = state_op(state_d);
    if ((state_d == ST_POP) || (state_d == ST_REMOVE)) begin
      draw_idx_d = idx_d;
    end else begin
      draw_idx_d = '0;
    end
    ld_d     = {state_d == ST_INIT, state_d == ST_RESET_LOOP, state_d == ST_MOVE_PAD,
                state_d == ST_MOVE_BALL, state_d == ST_COLLIDE};
    status_d = {state_d == ST_GAME_OVER, state_d == ST_LEVEL_CLEAR};
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_INIT;
      idx_q      <= '0;
      alive_q    <= '1;
      lives_q    <= LIFE_W'(LIVES);
      pend_q     <= 1'b0;
      draw_op_q  <= OP_NOP;
      draw_idx_q <= '0;
      ld_q       <= 5'b10000;
      status_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      alive_q    <= alive_d;
      lives_q    <= lives_d;
      pend_q     <= pend_d;
      draw_op_q  <= draw_op_d;
      draw_idx_q <= draw_idx_d;
      ld_q       <= ld_d;
      status_q   <= status_d;
    end
  end

  assign draw_op     = draw_op_q;
  assign draw_idx    = draw_idx_q;
  assign {ld_reset_initial, ld_reset_loop, ld_move_paddle, ld_move_ball, ld_collide} = ld_q;
  assign brick_alive = alive_q;
  assign lives       = lives_q;
  assign game_over   = status_q[1];
  assign level_clear = status_q[0];

endmodule

// File: doc/breakout_sequencer.md
Name: breakout_sequencer

Overview:
- Parametrised top-level game controller for the FPGA Breakout design. Sits between the game datapath (paddle/ball/collision registers) and the single VGA draw engine.
- Generalises the fixed 12-brick controller to NUM_BRICKS bricks. Replaces per-brick busy inputs with one start/done handshake and an opcode+index draw command.
- Adds frame pacing, an internal brick-alive bitmap, lives, game-over and level-clear handling.

Parameters:
- NUM_BRICKS, 12, number of bricks; valid range 1..30.
- BIDX_W, $clog2(NUM_BRICKS+1), width of the brick index; index 0 means "no brick".
- LIVES, 3, lives loaded at game start; 1..(2^LIFE_W - 1).
- LIFE_W, 2, width of the lives counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle restart request; honoured only in GAME_OVER and LEVEL_CLEAR.
- frame_tick  in  1  one-cycle pulse per video frame.
- draw_done  in  1  one-cycle pulse from the draw engine when the current job completes.
- hit_brick  in  BIDX_W  collision result, valid in COLLIDE; 0 means none.
- ball_lost  in  1  ball passed the paddle; valid in COLLIDE.
- draw_start  out  1  one-cycle pulse launching a draw job.
- draw_op  out  3  job opcode: 0 NOP, 1 SCREEN_CLEAR, 2 BRICK_FILL, 3 BRICK_CLEAR, 4 PADDLE_ERASE, 5 PADDLE_DRAW, 6 BALL_ERASE, 7 BALL_DRAW.
- draw_idx  out  BIDX_W  brick index for opcodes 2 and 3; otherwise 0.
- ld_reset_initial, ld_reset_loop, ld_move_paddle, ld_move_ball, ld_collide  out  1 each  datapath strobes, one cycle each.
- brick_alive  out  NUM_BRICKS  bit i-1 is set while brick i is on screen.
- lives  out  LIFE_W  remaining lives.
- game_over, level_clear  out  1 each  status; high for the whole time the FSM is in the matching state.

Behaviour:
- Reset (async, resetn low):
  - state = INIT; draw_start = 0; draw_op = 0; draw_idx = 0.
  - brick_alive = all ones; lives = LIVES; frame-pending flag = 0.
  - ld_reset_initial = 1 while the FSM is held in INIT; all other strobes = 0.
- Draw states (CLR, POP, ERASE_PAD, DRAW_PAD, ERASE_BALL, DRAW_BALL, REMOVE):
  - draw_op/draw_idx are stable for the whole state.
  - draw_start = 1 in the first cycle only.
  - draw_done is ignored in the first cycle. From the second cycle, draw_done exits the state on the next edge.
  - With no draw_done, the FSM waits indefinitely.
- Opcode is decoded from state. draw_idx is a registered brick counter.
- Transitions:
  - INIT (1 cycle; reload bitmap and lives) -> CLR (SCREEN_CLEAR) -> POP with idx = 1.
  - POP (BRICK_FILL, idx): on done, if idx == NUM_BRICKS go to RESET_LOOP, else idx + 1 and re-enter POP with a fresh draw_start.
  - RESET_LOOP (ld_reset_loop, 1 cycle) -> WAIT_FRAME.
  - WAIT_FRAME exits when frame_tick is high or the pending flag is set. Pending is set by any frame_tick outside WAIT_FRAME and cleared on the exit edge. At most one tick is queued.
  - Main loop: MOVE_PAD (ld_move_paddle, 1 cycle) -> ERASE_PAD -> DRAW_PAD -> ERASE_BALL -> MOVE_BALL (ld_move_ball, 1 cycle) -> DRAW_BALL -> COLLIDE (ld_collide, 1 cycle).
  - COLLIDE priority:
    - ball_lost -> LOST.
    - Else 1 <= hit_brick <= NUM_BRICKS and alive -> REMOVE with idx = hit_brick.
    - Else (0, out of range, or already dead) -> WAIT_FRAME.
  - REMOVE (BRICK_CLEAR): on done, clear alive bit idx-1. If the bitmap becomes zero go to LEVEL_CLEAR, else RESET_LOOP.
  - LOST (1 cycle): lives <= lives - 1. If lives was 1 go to GAME_OVER, else RESET_LOOP. The counter never wraps below 0.
  - GAME_OVER: start -> INIT, which reloads lives and bricks.
  - LEVEL_CLEAR: start -> POP with idx = 1; bitmap reloads to all ones; lives are kept.
  - In both terminal states, frame_tick and draw_done are ignored; start in any other state is ignored.
- Simultaneous events:
  - ball_lost together with a valid hit: loss wins and the brick stays alive.
  - frame_tick in the same cycle as the WAIT_FRAME exit: consumed, not queued.
- Reset mid-operation: all of the above reset values apply immediately. A draw job already in flight in the engine is not the block's concern.
- Unused state encodings go to INIT.

Decomposition:
- breakout_pkg holds:
  - draw opcode localparams (OP_NOP..OP_BALL_DRAW);
  - state encoding constants;
  - a function clog2 for BIDX_W.
- Sub-module breakout_draw_req: tracks first-cycle/issued status and generates the draw_start pulse and the done-accept qualifier. The sequencer instantiates it once.

Test Plan:
- Release reset with NUM_BRICKS=12 and draw_done returned 3 cycles after each start:
  - draw_start fires once for CLR, then 12 BRICK_FILL jobs with idx 1..12 in order;
  - ld_reset_loop fires once; the FSM then waits for frame_tick.
- One frame with hit_brick=5 in COLLIDE:
  - draw ops 4, 5, 6, 7 in order, ld_move_ball between ops 6 and 7;
  - then BRICK_CLEAR idx 5 and brick_alive = 12'hFEF;
  - hit_brick=5 on the next frame -> no REMOVE.
- hit_brick=13 or 15 -> treated as no hit; frame_tick pulsed mid-loop -> the next WAIT_FRAME exits without a new tick; two ticks mid-loop -> only one frame executes.
- ball_lost=1 three times with LIVES=3:
  - lives goes 2, 1, 0; game_over = 1;
  - start -> INIT with lives = 3 and brick_alive = all ones.
- ball_lost and hit_brick=2 together -> lives decrements and brick_alive bit 1 stays set.
- Remove all bricks with NUM_BRICKS=2:
  - level_clear = 1 and lives unchanged;
  - start -> repopulation of idx 1..2;
  - resetn pulsed low mid-POP -> draw_start = 0 and state = INIT asynchronously.
